// File: rtl/picomips_decoder_seq.sv
// Sequential instruction decoder / control unit for the picoMIPS core.
// Mealy decode from state, opcode, MUL counter and registered Z/N flags.
module picomips_decoder_seq #(
    parameter int OPW        = 6,
    parameter int MUL_CYCLES = 3,
    parameter int BR_BUBBLE  = 1
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [OPW-1:0] opcode,
    input  logic           z_in,
    input  logic           n_in,
    input  logic           ext_ready,
    output logic           pc_incr,
    output logic           pc_branch,
    output logic           pc_jump,
    output logic           imm,
    output logic           w1,
    output logic [2:0]     alu_func,
    output logic           busy,
    output logic           halted,
    output logic           illegal
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_MULW   = 3'd2;
    localparam logic [2:0] S_BUBBLE = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_MUL    = 3'b011;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h01);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(6'h06);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'h09);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_WAIT = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'h3F);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zf_q, zf_d;
    logic             nf_q, nf_d;
    logic             flag_upd;
    logic             br_taken;

    // N flag is tracked for future signed branches; no current opcode reads it.
    logic unused_nf;
    assign unused_nf = nf_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zf_d      = zf_q;
        nf_d      = nf_q;
        flag_upd  = 1'b0;
        br_taken  = 1'b0;
        pc_incr   = 1'b0;
        pc_branch = 1'b0;
        pc_jump   = 1'b0;
        imm       = 1'b0;
        w1        = 1'b0;
        alu_func  = ALU_PASS_B;
        busy      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_START: state_d = S_RUN;

            S_RUN: begin
                pc_incr = 1'b1;
                case (opcode)
                    OP_NOP: ;
                    OP_ADD: begin
                        w1 = 1'b1; alu_func = ALU_ADD; flag_upd = 1'b1;
                    end
                    OP_ADDI: begin
                        w1 = 1'b1; imm = 1'b1; alu_func = ALU_ADD; flag_upd = 1'b1;
                    end
                    OP_SUB: begin
                        w1 = 1'b1; alu_func = ALU_SUB; flag_upd = 1'b1;
                    end
                    OP_SUBI: begin
                        w1 = 1'b1; imm = 1'b1; alu_func = ALU_SUB; flag_upd = 1'b1;
                    end
                    OP_LDI: begin
                        w1 = 1'b1; imm = 1'b1; alu_func = ALU_PASS_B;
                    end
                    OP_MUL: begin
                        alu_func = ALU_MUL;
                        if (MUL_CYCLES == 1) begin
                            w1 = 1'b1; flag_upd = 1'b1;
                        end else begin
                            pc_incr = 1'b0;
                            busy    = 1'b1;
                            cnt_d   = CNT_INIT;
                            state_d = S_MULW;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        br_taken = (opcode == OP_BEQ) ? zf_q : ~zf_q;
                        if (br_taken) begin
                            pc_branch = 1'b1;
                            pc_incr   = 1'b0;
                            if (BR_BUBBLE != 0) state_d = S_BUBBLE;
                        end
                    end
                    OP_JMP: begin
                        pc_jump = 1'b1;
                        pc_incr = 1'b0;
                        if (BR_BUBBLE != 0) state_d = S_BUBBLE;
                    end
                    OP_WAIT: begin
                        pc_incr = ext_ready;
                        busy    = ~ext_ready;
                    end
                    OP_HALT: begin
                        pc_incr = 1'b0;
                        state_d = S_HALTED;
                    end
                    default: illegal = 1'b1;
                endcase
            end

            // Opcode is ignored here; the multiply result is written in the last cycle.
            S_MULW: begin
                alu_func = ALU_MUL;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q > CNT_ONE) begin
                    busy = 1'b1;
                end else begin
                    w1       = 1'b1;
                    pc_incr  = 1'b1;
                    flag_upd = 1'b1;
                    state_d  = S_RUN;
                end
            end

            S_BUBBLE: state_d = S_RUN;

            S_HALTED: halted = 1'b1;

            default: state_d = S_START;
        endcase

        if (flag_upd) begin
            zf_d = z_in;
            nf_d = n_in;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_START;
            cnt_q   <= '0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
        end
    end

endmodule

// File: tb/tb_picomips_decoder_seq.sv
// Directed, table-driven bench for picomips_decoder_seq (MUL_CYCLES=3),
// with a second instance using BR_BUBBLE=0 for the no-bubble case.
module tb_picomips_decoder_seq;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [5:0] opcode;
    logic       z_in, n_in, ext_ready;

    logic       pc_incr, pc_branch, pc_jump, imm, w1, busy, halted, illegal;
    logic [2:0] alu_func;
    logic       b_pc_incr, b_pc_branch, b_pc_jump, b_imm, b_w1, b_busy, b_halted, b_illegal;
    logic [2:0] b_alu_func;

    logic [10:0] out_m, out_b;
    assign out_m = {pc_incr, pc_branch, pc_jump, imm, w1, alu_func, busy, halted, illegal};
    assign out_b = {b_pc_incr, b_pc_branch, b_pc_jump, b_imm, b_w1, b_alu_func, b_busy, b_halted, b_illegal};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    picomips_decoder_seq #(.OPW(6), .MUL_CYCLES(3), .BR_BUBBLE(1)) dut (
        .clk(clk), .n_reset(n_reset), .opcode(opcode), .z_in(z_in), .n_in(n_in),
        .ext_ready(ext_ready), .pc_incr(pc_incr), .pc_branch(pc_branch), .pc_jump(pc_jump),
        .imm(imm), .w1(w1), .alu_func(alu_func), .busy(busy), .halted(halted), .illegal(illegal)
    );

    picomips_decoder_seq #(.OPW(6), .MUL_CYCLES(3), .BR_BUBBLE(0)) dut_nb (
        .clk(clk), .n_reset(n_reset), .opcode(opcode), .z_in(z_in), .n_in(n_in),
        .ext_ready(ext_ready), .pc_incr(b_pc_incr), .pc_branch(b_pc_branch), .pc_jump(b_pc_jump),
        .imm(b_imm), .w1(b_w1), .alu_func(b_alu_func), .busy(b_busy), .halted(b_halted),
        .illegal(b_illegal)
    );

    // {pc_incr, pc_branch, pc_jump, imm, w1, alu_func, busy, halted, illegal}
    function automatic logic [10:0] o(input logic pi, input logic pb, input logic pj,
                                      input logic im, input logic w, input logic [2:0] af,
                                      input logic b, input logic h, input logic il);
        return {pi, pb, pj, im, w, af, b, h, il};
    endfunction

    localparam logic [10:0] ZERO = 11'b0;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        er;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (pi pb pj imm w1 alu busy halt ill)", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic z, input logic er);
        opcode = op; z_in = z; ext_ready = er;
    endtask

    task automatic step(input logic [5:0] op, input logic z, input logic er,
                        input logic [10:0] exp, input string nm);
        drive(op, z, er);
        @(negedge clk);
        chk(nm, out_m, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_reset = 1'b0;
        n_in    = 1'b0;
        drive(6'h01, 1'b0, 1'b0);

        tbl.push_back('{6'h01, 1'b0, 1'b0, o(1,0,0,0,1,3'b001,0,0,0)}); // ADD, zf=0
        tbl.push_back('{6'h05, 1'b1, 1'b0, o(1,0,0,1,1,3'b000,0,0,0)}); // LDI, flags kept
        tbl.push_back('{6'h09, 1'b0, 1'b0, o(0,1,0,0,0,3'b000,0,0,0)}); // BNE taken
        tbl.push_back('{6'h01, 1'b0, 1'b0, ZERO});                      // bubble
        tbl.push_back('{6'h04, 1'b1, 1'b0, o(1,0,0,1,1,3'b010,0,0,0)}); // SUBI, zf=1
        tbl.push_back('{6'h08, 1'b0, 1'b0, o(0,1,0,0,0,3'b000,0,0,0)}); // BEQ taken
        tbl.push_back('{6'h03, 1'b1, 1'b0, ZERO});                      // bubble
        tbl.push_back('{6'h03, 1'b0, 1'b0, o(1,0,0,0,1,3'b010,0,0,0)}); // SUB, zf=0
        tbl.push_back('{6'h08, 1'b1, 1'b0, o(1,0,0,0,0,3'b000,0,0,0)}); // BEQ not taken
        tbl.push_back('{6'h09, 1'b0, 1'b0, o(0,1,0,0,0,3'b000,0,0,0)}); // BNE taken
        tbl.push_back('{6'h0A, 1'b0, 1'b0, ZERO});                      // bubble
        tbl.push_back('{6'h0A, 1'b0, 1'b0, o(0,0,1,0,0,3'b000,0,0,0)}); // JMP
        tbl.push_back('{6'h00, 1'b0, 1'b0, ZERO});                      // bubble
        tbl.push_back('{6'h00, 1'b0, 1'b0, o(1,0,0,0,0,3'b000,0,0,0)}); // NOP
        tbl.push_back('{6'h07, 1'b0, 1'b0, o(1,0,0,0,0,3'b000,0,0,1)}); // illegal 07
        tbl.push_back('{6'h02, 1'b0, 1'b0, o(1,0,0,1,1,3'b001,0,0,0)}); // ADDI
        tbl.push_back('{6'h0C, 1'b0, 1'b0, o(0,0,0,0,0,3'b000,1,0,0)}); // WAIT x4
        tbl.push_back('{6'h0C, 1'b0, 1'b0, o(0,0,0,0,0,3'b000,1,0,0)});
        tbl.push_back('{6'h0C, 1'b0, 1'b0, o(0,0,0,0,0,3'b000,1,0,0)});
        tbl.push_back('{6'h0C, 1'b0, 1'b0, o(0,0,0,0,0,3'b000,1,0,0)});
        tbl.push_back('{6'h0C, 1'b0, 1'b1, o(1,0,0,0,0,3'b000,0,0,0)}); // WAIT released
        tbl.push_back('{6'h06, 1'b0, 1'b0, o(0,0,0,0,0,3'b011,1,0,0)}); // MUL cycle 1
        tbl.push_back('{6'h0A, 1'b0, 1'b0, o(0,0,0,0,0,3'b011,1,0,0)}); // MUL cycle 2, opcode ignored
        tbl.push_back('{6'h3F, 1'b1, 1'b0, o(1,0,0,0,1,3'b011,0,0,0)}); // MUL cycle 3, zf=1
        tbl.push_back('{6'h08, 1'b0, 1'b0, o(0,1,0,0,0,3'b000,0,0,0)}); // BEQ sees MUL flag
        tbl.push_back('{6'h01, 1'b0, 1'b0, ZERO});                      // bubble
        tbl.push_back('{6'h0B, 1'b0, 1'b0, o(1,0,0,0,0,3'b000,0,0,1)}); // illegal 0B
        tbl.push_back('{6'h3F, 1'b0, 1'b0, ZERO});                      // HALT
        tbl.push_back('{6'h01, 1'b0, 1'b0, o(0,0,0,0,0,3'b000,0,1,0)}); // halted
        tbl.push_back('{6'h0A, 1'b0, 1'b0, o(0,0,0,0,0,3'b000,0,1,0)});
        tbl.push_back('{6'h06, 1'b0, 1'b1, o(0,0,0,0,0,3'b000,0,1,0)});

        // Held in reset with ADD on the bus
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_reset", out_m, ZERO);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        step(6'h01, 1'b0, 1'b0, ZERO, "start_cycle");

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].op, tbl[i].z, tbl[i].er, tbl[i].exp, $sformatf("vec%0d_op%02h", i, tbl[i].op));

        // Reset leaves HALTED
        n_reset = 1'b0;
        @(negedge clk);
        chk("halt_reset", out_m, ZERO);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        step(6'h06, 1'b0, 1'b0, ZERO, "start_after_halt");

        // Reset pulsed in the middle of a MUL
        step(6'h06, 1'b0, 1'b0, o(0,0,0,0,0,3'b011,1,0,0), "mulrst_c1");
        drive(6'h06, 1'b1, 1'b0);
        @(negedge clk);
        chk("mulrst_c2", out_m, o(0,0,0,0,0,3'b011,1,0,0));
        #1 n_reset = 1'b0;
        #1 chk("mulrst_async", out_m, ZERO);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        step(6'h06, 1'b1, 1'b0, ZERO, "mulrst_start");
        step(6'h08, 1'b0, 1'b0, o(1,0,0,0,0,3'b000,0,0,0), "beq_zf_cleared");

        // Same taken branch on both instances: only one inserts a bubble
        drive(6'h04, 1'b1, 1'b0);
        @(negedge clk);
        chk("nb_subi_main", out_m, o(1,0,0,1,1,3'b010,0,0,0));
        chk("nb_subi_nb", out_b, o(1,0,0,1,1,3'b010,0,0,0));
        @(posedge clk);
        #1;
        drive(6'h08, 1'b0, 1'b0);
        @(negedge clk);
        chk("nb_beq_main", out_m, o(0,1,0,0,0,3'b000,0,0,0));
        chk("nb_beq_nb", out_b, o(0,1,0,0,0,3'b000,0,0,0));
        @(posedge clk);
        #1;
        drive(6'h01, 1'b0, 1'b0);
        @(negedge clk);
        chk("nb_next_main", out_m, ZERO);
        chk("nb_next_nb", out_b, o(1,0,0,0,1,3'b001,0,0,0));
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
